// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    I2C_RX_IDLE,
    I2C_RX_ADDR,
    I2C_RX_ADDR_ACK,
    I2C_RX_DATA,
    I2C_RX_DATA_ACK,
    I2C_RX_IGNORE
  } i2c_rx_state_e;

  // A write request addressed to us: upper seven bits equal own address, R/W=0.
  function automatic logic addr_hit(input logic [I2C_BYTE_W-1:0] b,
                                    input logic [I2C_ADDR_W-1:0] own);
    return (b[I2C_BYTE_W-1:1] == own) && !b[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-stage synchronizer for one asynchronous bus line, with rise/fall pulses.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic line_i,
  output logic line_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Left unreset so that a reset never fabricates an edge on a live bus.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], line_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign line_s_o = sync_q[STAGES-1];
  assign rise_o   = sync_q[STAGES-1] & ~prev_q;
  assign fall_o   = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: START/STOP detect, address compare, ACK drive and
// a one-entry valid/ready holding register for received data bytes.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR    = 7'h12,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2c_scl,
  input  logic                  i2c_sda,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_first,
  output logic                  busy,
  output logic                  addr_match,
  output logic                  overrun
);

  localparam logic [3:0] LAST_BIT  = 4'(I2C_BYTE_W - 1);
  localparam logic [3:0] BYTE_DONE = 4'(I2C_BYTE_W);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk      (clk),
    .line_i   (i2c_scl),
    .line_s_o (scl_s),
    .rise_o   (scl_rise),
    .fall_o   (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk      (clk),
    .line_i   (i2c_sda),
    .line_s_o (sda_s),
    .rise_o   (sda_rise),
    .fall_o   (sda_fall)
  );

  i2c_rx_state_e         state_q;
  logic [3:0]            bit_cnt_q;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  sda_oe_q, rx_valid_q, rx_first_q, busy_q;
  logic                  addr_match_q, overrun_q, first_pend_q, nack_q;
  logic [I2C_BYTE_W-1:0] rx_data_q;
  logic                  scl_hi2, start_det, stop_det, can_load;

  // SCL high now and last cycle is equivalent to high without a fresh rise.
  assign scl_hi2   = scl_s & ~scl_rise;
  assign start_det = sda_fall & scl_hi2;
  assign stop_det  = sda_rise & scl_hi2;
  assign shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
  assign can_load  = !rx_valid_q || rx_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= I2C_RX_IDLE;
      bit_cnt_q    <= '0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
      overrun_q    <= 1'b0;
      first_pend_q <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (stop_det) begin
        state_q      <= I2C_RX_IDLE;
        bit_cnt_q    <= '0;
        sda_oe_q     <= 1'b0;
        busy_q       <= 1'b0;
        addr_match_q <= 1'b0;
      end else if (start_det) begin
        state_q      <= I2C_RX_ADDR;
        bit_cnt_q    <= '0;
        sda_oe_q     <= 1'b0;
        busy_q       <= 1'b1;
        addr_match_q <= 1'b0;
      end else begin
        case (state_q)
          I2C_RX_ADDR: begin
            if (scl_rise && bit_cnt_q < BYTE_DONE) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) addr_match_q <= addr_hit(shift_d, OWN_ADDR);
            end else if (scl_fall && bit_cnt_q == BYTE_DONE) begin
              state_q   <= I2C_RX_ADDR_ACK;
              sda_oe_q  <= addr_match_q;
              bit_cnt_q <= '0;
            end
          end
          I2C_RX_ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              if (addr_match_q) begin
                state_q      <= I2C_RX_DATA;
                first_pend_q <= 1'b1;
              end else begin
                state_q <= I2C_RX_IGNORE;
              end
            end
          end
          I2C_RX_DATA: begin
            if (scl_rise && bit_cnt_q < BYTE_DONE) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                // A drain in this same cycle frees the slot for the new byte.
                if (can_load) begin
                  rx_data_q    <= shift_d;
                  rx_valid_q   <= 1'b1;
                  rx_first_q   <= first_pend_q;
                  first_pend_q <= 1'b0;
                  nack_q       <= 1'b0;
                end else begin
                  overrun_q <= 1'b1;
                  nack_q    <= 1'b1;
                end
              end
            end else if (scl_fall && bit_cnt_q == BYTE_DONE) begin
              state_q   <= I2C_RX_DATA_ACK;
              sda_oe_q  <= ~nack_q;
              bit_cnt_q <= '0;
            end
          end
          I2C_RX_DATA_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= I2C_RX_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_first   = rx_first_q;
  assign busy       = busy_q;
  assign addr_match = addr_match_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed and randomized I2C write transactions against a byte-level model.
module tb_i2c_target_rx;

  localparam logic [6:0] OWN = 7'h12;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset, scl, sda_m, rx_ready;
  logic       sda_wire;
  logic       sda_oe, rx_valid, rx_first, busy, addr_match, overrun;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic oe_seen = 1'b0;
  logic am_seen = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] data_buf[4];

  always #5 clk = ~clk;

  assign sda_wire = sda_m & ~sda_oe;

  i2c_target_rx #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_scl    (scl),
    .i2c_sda    (sda_wire),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_first   (rx_first),
    .busy       (busy),
    .addr_match (addr_match),
    .overrun    (overrun)
  );

  always @(posedge clk) begin
    if (reset && rx_valid && rx_ready) got_q.push_back({rx_first, rx_data});
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (sda_oe) oe_seen = 1'b1;
    if (addr_match) am_seen = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wq(Q);
    scl = 1'b1;   wq(Q);
    sda_m = 1'b0; wq(Q);
    scl = 1'b0;   wq(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wq(Q);
    scl = 1'b1;   wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic m_bit(input logic b);
    sda_m = b;  wq(Q);
    scl = 1'b1; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic m_ack(output logic a);
    sda_m = 1'b1; wq(Q);
    scl = 1'b1;   wq(Q / 2);
    a = ~sda_wire;
    wq(Q / 2);
    scl = 1'b0;   wq(Q);
  endtask

  task automatic m_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    m_ack(a);
  endtask

  // Full transaction with rx_ready held high; model decides ACKs and deliveries.
  task automatic do_txn(input logic [6:0] a, input logic rw, input int n);
    logic ack, hit;
    hit = (a == OWN) && !rw;
    m_start();
    m_byte({a, rw}, ack);
    chk("addr_ack", 32'(ack), 32'(hit));
    chk("busy_mid", 32'(busy), 32'(1));
    for (int i = 0; i < n; i++) begin
      m_byte(data_buf[i], ack);
      chk("data_ack", 32'(ack), 32'(hit));
      if (hit) exp_q.push_back({(i == 0), data_buf[i]});
    end
    m_stop();
    wq(6);
    chk("busy_after_stop", 32'(busy), 32'(0));
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic ack;
    logic [6:0] ra;
    logic rrw;
    int rn;
    reset = 1'b0; scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
    wq(6);
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_first", 32'(rx_first), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_addr_match", 32'(addr_match), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    reset = 1'b1;
    wq(10);

    // Address match, single data byte.
    am_seen = 1'b0;
    data_buf[0] = 8'hAA;
    do_txn(OWN, 1'b0, 1);
    chk("match_addr_match_seen", 32'(am_seen), 32'(1));
    cmp_q("match_deliver");

    // Address mismatch.
    oe_seen = 1'b0; am_seen = 1'b0;
    data_buf[0] = 8'h55;
    do_txn(7'h2C, 1'b0, 1);
    chk("mismatch_oe_seen", 32'(oe_seen), 32'(0));
    chk("mismatch_am_seen", 32'(am_seen), 32'(0));
    cmp_q("mismatch_deliver");

    // Backpressure: second byte dropped.
    rx_ready = 1'b0; ovr_cnt = 0;
    m_start();
    m_byte({OWN, 1'b0}, ack);
    chk("bp_addr_ack", 32'(ack), 32'(1));
    m_byte(8'h01, ack);
    chk("bp_b1_ack", 32'(ack), 32'(1));
    m_byte(8'h02, ack);
    chk("bp_b2_ack", 32'(ack), 32'(0));
    chk("bp_overrun_cnt", 32'(ovr_cnt), 32'(1));
    chk("bp_rx_data", 32'(rx_data), 32'(8'h01));
    chk("bp_rx_valid", 32'(rx_valid), 32'(1));
    m_stop();
    wq(4);
    chk("bp_valid_after_stop", 32'(rx_valid), 32'(1));
    rx_ready = 1'b1;
    wq(4);
    exp_q.push_back({1'b1, 8'h01});
    cmp_q("bp_deliver");

    // Read request is NACKed and ignored.
    oe_seen = 1'b0;
    data_buf[0] = 8'h77;
    do_txn(OWN, 1'b1, 1);
    chk("read_oe_seen", 32'(oe_seen), 32'(0));
    cmp_q("read_deliver");

    // Repeated START after three data bits.
    m_start();
    m_byte({OWN, 1'b0}, ack);
    chk("rs_addr_ack1", 32'(ack), 32'(1));
    m_bit(1'b1); m_bit(1'b0); m_bit(1'b1);
    m_start();
    m_byte({OWN, 1'b0}, ack);
    chk("rs_addr_ack2", 32'(ack), 32'(1));
    m_byte(8'h00, ack);
    chk("rs_data_ack", 32'(ack), 32'(1));
    m_stop();
    wq(6);
    exp_q.push_back({1'b1, 8'h00});
    cmp_q("rs_deliver");

    // Reset asserted during the data ACK slot.
    rx_ready = 1'b0;
    m_start();
    m_byte({OWN, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) m_bit(1'((8'hAA >> i) & 8'h01));
    sda_m = 1'b1; wq(Q);
    scl = 1'b1;   wq(2);
    chk("rst_mid_oe_before", 32'(sda_oe), 32'(1));
    chk("rst_mid_valid_before", 32'(rx_valid), 32'(1));
    reset = 1'b0;
    wq(1);
    reset = 1'b1;
    chk("rst_mid_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_mid_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_mid_rx_data", 32'(rx_data), 32'(0));
    chk("rst_mid_rx_first", 32'(rx_first), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_addr_match", 32'(addr_match), 32'(0));
    chk("rst_mid_overrun", 32'(overrun), 32'(0));
    wq(Q);
    scl = 1'b0; wq(Q);
    m_bit(1'b0);
    chk("rst_idle_oe", 32'(sda_oe), 32'(0));
    m_stop();
    rx_ready = 1'b1;
    wq(6);
    data_buf[0] = 8'hAA;
    do_txn(OWN, 1'b0, 1);
    cmp_q("rst_recover_deliver");

    // Randomized transactions.
    for (int t = 0; t < 5; t++) begin
      ra  = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom_range(0, 127));
      rrw = ($urandom_range(0, 3) == 0);
      rn  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) data_buf[i] = 8'($urandom);
      do_txn(ra, rrw, rn);
      cmp_q("rand_deliver");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
